// File: rtl/march_bist_sequencer.sv
// March C- BIST sequencer for a synchronous-read RAM: drives addresses, write data and enable,
// checks read data, and reports the first failing address and element.
module march_bist_sequencer #(
    parameter int unsigned   AW = 10,
    parameter int unsigned   DW = 8,
    parameter logic [DW-1:0] BG = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] ram_rd_data,
    output logic [AW-1:0] ram_rd_addrs,
    output logic [AW-1:0] ram_wrt_addrs,
    output logic [DW-1:0] ram_wrt_dat,
    output logic          ram_wrt_en,
    output logic          bist_active,
    output logic          done,
    output logic          pass,
    output logic [AW-1:0] fail_addr,
    output logic [2:0]    fail_elem
);

    typedef enum logic [2:0] {StIdle, StWr, StRd, StChk, StPass, StFail} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [2:0]    elem_q, elem_d;
    logic [AW-1:0] fail_addr_q, fail_addr_d;
    logic [2:0]    fail_elem_q, fail_elem_d;

    logic          down;
    logic          last_addr;
    logic [DW-1:0] exp_data;
    logic [AW-1:0] next_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            elem_q      <= '0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            elem_q      <= elem_d;
            fail_addr_q <= fail_addr_d;
            fail_elem_q <= fail_elem_d;
        end
    end

    // Odd elements read the "0" background, even elements read "1"; writes are the opposite.
    always_comb begin
        down       = (elem_q == 3'd3) || (elem_q == 3'd4);
        last_addr  = down ? (addr_q == '0) : (&addr_q);
        exp_data   = elem_q[0] ? BG : ~BG;
        next_start = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? '1 : '0;
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        elem_d        = elem_q;
        fail_addr_d   = fail_addr_q;
        fail_elem_d   = fail_elem_q;
        ram_rd_addrs  = '0;
        ram_wrt_addrs = '0;
        ram_wrt_dat   = '0;
        ram_wrt_en    = 1'b0;
        bist_active   = 1'b0;
        done          = 1'b0;
        pass          = 1'b0;

        unique case (state_q)
            StIdle, StPass, StFail: begin
                done = (state_q != StIdle);
                pass = (state_q == StPass);
                if (start) begin
                    state_d     = StWr;
                    addr_d      = '0;
                    elem_d      = '0;
                    fail_addr_d = '0;
                    fail_elem_d = '0;
                end
            end
            StWr: begin
                bist_active   = 1'b1;
                ram_wrt_en    = 1'b1;
                ram_wrt_addrs = addr_q;
                ram_wrt_dat   = BG;
                if (&addr_q) begin
                    elem_d  = 3'd1;
                    addr_d  = '0;
                    state_d = StRd;
                end else begin
                    addr_d = addr_q + AW'(1);
                end
            end
            StRd: begin
                bist_active  = 1'b1;
                ram_rd_addrs = addr_q;
                state_d      = StChk;
            end
            StChk: begin
                bist_active  = 1'b1;
                ram_rd_addrs = addr_q;
                if (ram_rd_data != exp_data) begin
                    fail_addr_d = addr_q;
                    fail_elem_d = elem_q;
                    state_d     = StFail;
                end else begin
                    if (elem_q != 3'd5) begin
                        ram_wrt_en    = 1'b1;
                        ram_wrt_addrs = addr_q;
                        ram_wrt_dat   = ~exp_data;
                    end
                    if (last_addr) begin
                        if (elem_q == 3'd5) begin
                            state_d = StPass;
                        end else begin
                            elem_d  = elem_q + 3'd1;
                            addr_d  = next_start;
                            state_d = StRd;
                        end
                    end else begin
                        addr_d  = down ? addr_q - AW'(1) : addr_q + AW'(1);
                        state_d = StRd;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign fail_addr = fail_addr_q;
    assign fail_elem = fail_elem_q;

endmodule

// File: tb/tb_march_bist_sequencer.sv
// Bench for march_bist_sequencer: behavioural 1024x8 sync-read RAM with user/BIST muxes and
// per-address stuck-at fault injection on the read path.
module tb_march_bist_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  ram_rd_data;
    logic [9:0]  ram_rd_addrs, ram_wrt_addrs, fail_addr;
    logic [7:0]  ram_wrt_dat;
    logic        ram_wrt_en, bist_active, done, pass;
    logic [2:0]  fail_elem;

    logic [9:0]  u_ra = '0, u_wa = '0;
    logic [7:0]  u_wd = '0;
    logic        u_we = 1'b0;

    logic [9:0]  sa1_addr = '0, sa0_addr = '0;
    logic [7:0]  sa1_mask = '0, sa0_mask = '0;

    logic [7:0]  mem [0:1023];
    logic [7:0]  rd_q = '0;
    logic [9:0]  m_ra, m_wa;
    logic [7:0]  m_wd;
    logic        m_we;

    int total = 0;
    int bad = 0;
    int wr_cnt = 0;

    march_bist_sequencer #(.AW(10), .DW(8), .BG(8'h00)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .ram_rd_data  (ram_rd_data),
        .ram_rd_addrs (ram_rd_addrs),
        .ram_wrt_addrs(ram_wrt_addrs),
        .ram_wrt_dat  (ram_wrt_dat),
        .ram_wrt_en   (ram_wrt_en),
        .bist_active  (bist_active),
        .done         (done),
        .pass         (pass),
        .fail_addr    (fail_addr),
        .fail_elem    (fail_elem)
    );

    always #5 clk = ~clk;

    assign m_ra = bist_active ? ram_rd_addrs : u_ra;
    assign m_wa = bist_active ? ram_wrt_addrs : u_wa;
    assign m_wd = bist_active ? ram_wrt_dat : u_wd;
    assign m_we = bist_active ? ram_wrt_en : u_we;
    assign ram_rd_data = rd_q;

    always @(posedge clk) begin
        if (m_we) mem[m_wa] <= m_wd;
        rd_q <= (mem[m_ra] | ((m_ra == sa1_addr) ? sa1_mask : 8'h00))
                & ~((m_ra == sa0_addr) ? sa0_mask : 8'h00);
        if (bist_active && ram_wrt_en) wr_cnt <= wr_cnt + 1;
    end

    // Pulses start, optionally re-pulses it at cycle restart_at, and waits for done.
    // n is the cycle count from the start edge to done, or -1 on timeout.
    task automatic run_to_done(input int restart_at, output int n, output bit bist_ok,
                               output logic [9:0] fa0, output logic done0);
        @(negedge clk);
        wr_cnt = 0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        fa0 = fail_addr;
        done0 = done;
        n = 0;
        bist_ok = 1'b1;
        while (!done && n < 20000) begin
            if (!bist_active) bist_ok = 1'b0;
            @(posedge clk);
            #1;
            n++;
            start = (n == restart_at);
        end
        start = 1'b0;
        if (!done) n = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({ram_rd_addrs, ram_wrt_addrs, ram_wrt_dat, ram_wrt_en, bist_active, done, pass,
             fail_addr, fail_elem} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got rd=%h wa=%h wd=%h we=%b act=%b done=%b pass=%b fa=%h fe=%0d want all 0",
                     ram_rd_addrs, ram_wrt_addrs, ram_wrt_dat, ram_wrt_en, bist_active, done,
                     pass, fail_addr, fail_elem);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_healthy_pass();
        int n; bit ok; logic [9:0] fa0; logic d0;
        run_to_done(-1, n, ok, fa0, d0);
        total++;
        if (n !== 11264) begin bad++; $display("FAIL pass_latency: got %0d want 11264", n); end
        total++;
        if (pass !== 1'b1) begin bad++; $display("FAIL pass_flag: got %b want 1", pass); end
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL bist_active_run: got dropout want steady 1"); end
        total++;
        if (wr_cnt !== 5120) begin bad++; $display("FAIL pass_write_count: got %0d want 5120", wr_cnt); end
        total++;
        if (d0 !== 1'b0) begin bad++; $display("FAIL done_clear_on_start: got %b want 0", d0); end
        total++;
        if (bist_active !== 1'b0 || ram_wrt_en !== 1'b0 || ram_rd_addrs !== 10'h0) begin
            bad++;
            $display("FAIL pass_release: got act=%b we=%b rd=%h want 0 0 000",
                     bist_active, ram_wrt_en, ram_rd_addrs);
        end
    endtask

    task automatic test_stuck_at1();
        int n; bit ok; logic [9:0] fa0; logic d0;
        sa1_addr = 10'h155; sa1_mask = 8'h08;
        run_to_done(-1, n, ok, fa0, d0);
        sa1_mask = 8'h00;
        total++;
        if (n !== 1024 + 2 * 10'h155 + 2) begin
            bad++; $display("FAIL sa1_latency: got %0d want %0d", n, 1024 + 2 * 10'h155 + 2);
        end
        total++;
        if (done !== 1'b1 || pass !== 1'b0) begin
            bad++; $display("FAIL sa1_status: got done=%b pass=%b want 1 0", done, pass);
        end
        total++;
        if (fail_addr !== 10'h155 || fail_elem !== 3'd1) begin
            bad++; $display("FAIL sa1_report: got addr=%h elem=%0d want 155 1", fail_addr, fail_elem);
        end
        total++;
        if (wr_cnt !== 1024 + 10'h155) begin
            bad++; $display("FAIL sa1_write_count: got %0d want %0d", wr_cnt, 1024 + 10'h155);
        end
    endtask

    task automatic test_stuck_at0();
        int n; bit ok; logic [9:0] fa0; logic d0; int w;
        sa0_addr = 10'h3FF; sa0_mask = 8'h01;
        run_to_done(-1, n, ok, fa0, d0);
        total++;
        if (fa0 !== 10'h000 || d0 !== 1'b0) begin
            bad++; $display("FAIL fail_clear_on_start: got addr=%h done=%b want 000 0", fa0, d0);
        end
        total++;
        if (fail_addr !== 10'h3FF || fail_elem !== 3'd2 || pass !== 1'b0) begin
            bad++;
            $display("FAIL sa0_report: got addr=%h elem=%0d pass=%b want 3ff 2 0",
                     fail_addr, fail_elem, pass);
        end
        total++;
        if (wr_cnt !== 3071) begin bad++; $display("FAIL sa0_write_count: got %0d want 3071", wr_cnt); end
        w = wr_cnt;
        repeat (20) @(posedge clk);
        #1;
        total++;
        if (wr_cnt !== w || ram_wrt_en !== 1'b0 || fail_addr !== 10'h3FF || done !== 1'b1) begin
            bad++;
            $display("FAIL sa0_hold: got writes=%0d we=%b addr=%h done=%b want %0d 0 3ff 1",
                     wr_cnt, ram_wrt_en, fail_addr, done, w);
        end
        sa0_mask = 8'h00;
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4999) @(posedge clk);
        #1;
        total++;
        if (bist_active !== 1'b1 || done !== 1'b0) begin
            bad++; $display("FAIL pre_reset_running: got act=%b done=%b want 1 0", bist_active, done);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (ram_wrt_en !== 1'b0 || bist_active !== 1'b0 || done !== 1'b0 || ram_wrt_addrs !== 10'h0) begin
            bad++;
            $display("FAIL mid_reset: got we=%b act=%b done=%b wa=%h want 0 0 0 000",
                     ram_wrt_en, bist_active, done, ram_wrt_addrs);
        end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (bist_active !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL idle_after_reset: got act=%b done=%b want 0 0", bist_active, done);
        end
    endtask

    task automatic test_restart_ignored();
        int n; bit ok; logic [9:0] fa0; logic d0;
        run_to_done(100, n, ok, fa0, d0);
        total++;
        if (n !== 11264 || pass !== 1'b1) begin
            bad++; $display("FAIL restart_ignored: got n=%0d pass=%b want 11264 1", n, pass);
        end
    endtask

    task automatic test_user_access();
        @(negedge clk);
        u_we = 1'b1; u_wa = 10'd7; u_wd = 8'hA5;
        @(posedge clk);
        #1 u_we = 1'b0; u_ra = 10'd7;
        @(posedge clk);
        #1;
        total++;
        if (ram_rd_data !== 8'hA5) begin
            bad++; $display("FAIL user_readback: got %h want a5", ram_rd_data);
        end
        total++;
        if (done !== 1'b1 || pass !== 1'b1 || bist_active !== 1'b0) begin
            bad++;
            $display("FAIL pass_hold: got done=%b pass=%b act=%b want 1 1 0", done, pass, bist_active);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        test_reset();
        test_healthy_pass();
        test_stuck_at1();
        test_stuck_at0();
        test_mid_reset();
        test_restart_ignored();
        test_user_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
